// File: rtl/spi_master_burst.sv
// spi_master_burst: SPI master clocked by SCK, streams multi-word bursts under one slave select.
// Ports:
//   SCK       clock, all state changes on posedge
//   reset     asynchronous active-high reset
//   tx_data   word to transmit; tx_valid/tx_ready handshake, tx_last ends the frame
//   ss_sel    slave index, sampled only on the first word of a frame
//   SSB       registered active-low slave selects
//   MOSI      serial out, MISO serial in
//   rx_data   last received word, qualified by the one-cycle rx_valid pulse
//   busy      high whenever the controller is not idle
// Build option: define SPI_LOOPBACK_EN to add the loopback input (1 = sample MOSI instead of MISO).
module spi_master_burst #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SS = 1,
   parameter int MAX_WORDS = 4,
   parameter int LSB_FIRST = 0,
   parameter int IDLE_GAP = 1,
   localparam int SSW = NUM_SS > 1 ? $clog2(NUM_SS) : 1
) (
   input  logic                  SCK,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   input  logic                  tx_last,
   output logic                  tx_ready,
   input  logic [SSW-1:0]        ss_sel,
   output logic [NUM_SS-1:0]     SSB,
   output logic                  MOSI,
   input  logic                  MISO,
`ifdef SPI_LOOPBACK_EN
   input  logic                  loopback,
`endif
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy
);
   localparam int BW = $clog2(DATA_WIDTH) + 1;
   localparam int WW = $clog2(MAX_WORDS) + 1;
   localparam int GW = $clog2(IDLE_GAP) + 1;
   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
   state_t state, state_n;
   logic [DATA_WIDTH-1:0] shift_reg, shifted;
   logic [BW-1:0] bit_cnt;
   logic [WW-1:0] word_cnt;
   logic [GW-1:0] gap_cnt;
   logic [NUM_SS-1:0] ss_dec;
   logic last_q, sin, accept, final_bit, end_frame;
`ifdef SPI_LOOPBACK_EN
   assign sin = loopback ? MOSI : MISO;
`else
   assign sin = MISO;
`endif
   // The serial input fills the end of the register vacated by the outgoing bit.
   assign shifted = LSB_FIRST != 0 ? {sin, shift_reg[DATA_WIDTH-1:1]} : {shift_reg[DATA_WIDTH-2:0], sin};
   assign accept = tx_valid && tx_ready;
   assign final_bit = state == SHIFT && bit_cnt == BW'(DATA_WIDTH - 1);
   assign end_frame = last_q || word_cnt == WW'(MAX_WORDS);
   always_ff @(posedge SCK or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? SHIFT : IDLE;
         SHIFT:   state_n = !final_bit ? SHIFT : end_frame ? GAP : tx_valid ? SHIFT : HOLD;
         HOLD:    state_n = accept ? SHIFT : HOLD;
         GAP:     state_n = gap_cnt == GW'(IDLE_GAP - 1) ? IDLE : GAP;
         default: state_n = IDLE;
      endcase
   end
   // tx_ready opens in SHIFT only on the final bit of a word that may be followed seamlessly.
   always_comb begin
      tx_ready = state == IDLE || state == HOLD || (final_bit && !end_frame);
      MOSI = state == SHIFT && (LSB_FIRST != 0 ? shift_reg[0] : shift_reg[DATA_WIDTH-1]);
      busy = state != IDLE;
   end
   // Out-of-range indices match no line, so the frame runs with every select high.
   always_comb begin
      ss_dec = '1;
      for (int i = 0; i < NUM_SS; i++) ss_dec[i] = ss_sel != SSW'(i);
   end
   always_ff @(posedge SCK or posedge reset) begin
      if (reset) begin
         shift_reg <= '0;
         last_q <= 1'b0;
         bit_cnt <= '0;
         word_cnt <= '0;
         gap_cnt <= '0;
         SSB <= '1;
         rx_data <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= final_bit;
         gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
         if (final_bit) rx_data <= shifted;
         if (accept) begin
            shift_reg <= tx_data;
            last_q <= tx_last;
            bit_cnt <= '0;
            word_cnt <= state == IDLE ? WW'(1) : word_cnt + 1'b1;
         end else if (state == SHIFT) begin
            shift_reg <= shifted;
            bit_cnt <= bit_cnt + 1'b1;
         end
         if (state == IDLE && accept) SSB <= ss_dec;
         else if (final_bit && end_frame) SSB <= '1;
      end
   end
endmodule

// File: tb/tb_spi_master_burst.sv
// tb_spi_master_burst: scoreboard bench for spi_master_burst (MSB-first 3-select instance and LSB-first 4-select instance).
module tb_spi_master_burst;
   logic SCK = 1'b0;
   logic reset = 1'b1;
   always #5 SCK = ~SCK;
   logic [7:0] tx_data_a = '0, rx_data_a;
   logic tx_valid_a = 0, tx_last_a = 0, tx_ready_a, MOSI_a, MISO_a = 0, rx_valid_a, busy_a;
   logic [1:0] ss_sel_a = '0;
   logic [2:0] SSB_a;
   logic [7:0] tx_data_b = '0, rx_data_b;
   logic tx_valid_b = 0, tx_last_b = 0, tx_ready_b, MOSI_b, MISO_b = 0, rx_valid_b, busy_b;
   logic [1:0] ss_sel_b = '0;
   logic [3:0] SSB_b;
   spi_master_burst #(.DATA_WIDTH(8), .NUM_SS(3), .MAX_WORDS(4), .LSB_FIRST(0), .IDLE_GAP(1)) dut_a (
      .SCK(SCK), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_last(tx_last_a),
      .tx_ready(tx_ready_a), .ss_sel(ss_sel_a), .SSB(SSB_a), .MOSI(MOSI_a), .MISO(MISO_a),
`ifdef SPI_LOOPBACK_EN
      .loopback(1'b0),
`endif
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a));
   spi_master_burst #(.DATA_WIDTH(8), .NUM_SS(4), .MAX_WORDS(4), .LSB_FIRST(1), .IDLE_GAP(1)) dut_b (
      .SCK(SCK), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_last(tx_last_b),
      .tx_ready(tx_ready_b), .ss_sel(ss_sel_b), .SSB(SSB_b), .MOSI(MOSI_b), .MISO(MISO_b),
`ifdef SPI_LOOPBACK_EN
      .loopback(1'b0),
`endif
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b));
   int total = 0, bad = 0, cyc = 0;
   int run_a = 0, last_run_a = 0, rx_cnt_a = 0, rx_cyc_a = 0, prev_rx_cyc_a = 0, rx_cnt_b = 0;
   logic [2:0] pat_a = 3'b111;
   logic [7:0] exp_a[$], exp_b[$];
   // Pops the scoreboards on every rx_valid and measures contiguous select-low runs on instance a.
   task automatic monitor;
      logic [7:0] e;
      forever begin
         @(negedge SCK);
         cyc++;
         if (rx_valid_a) begin
            total++;
            rx_cnt_a++;
            prev_rx_cyc_a = rx_cyc_a;
            rx_cyc_a = cyc;
            if (exp_a.size() == 0) begin
               bad++;
               $display("FAIL rx_a_unexpected: rx_valid with rx_data=%h, required no pulse", rx_data_a);
            end else begin
               e = exp_a.pop_front();
               if (rx_data_a !== e) begin bad++; $display("FAIL rx_a_data: got %h, required %h", rx_data_a, e); end
            end
         end
         if (rx_valid_b) begin
            total++;
            rx_cnt_b++;
            if (exp_b.size() == 0) begin
               bad++;
               $display("FAIL rx_b_unexpected: rx_valid with rx_data=%h, required no pulse", rx_data_b);
            end else begin
               e = exp_b.pop_front();
               if (rx_data_b !== e) begin bad++; $display("FAIL rx_b_data: got %h, required %h", rx_data_b, e); end
            end
         end
         if (SSB_a !== 3'b111) begin
            run_a++;
            pat_a = SSB_a;
         end else if (run_a != 0) begin
            last_run_a = run_a;
            run_a = 0;
         end
      end
   endtask
   // Called at the negedge before the accept edge; returns at the negedge before the final-bit edge.
   task automatic shift_word(input logic [7:0] miso_w, input logic [7:0] nd, input logic nl, input logic nv,
                             output logic [7:0] cap);
      exp_a.push_back(miso_w);
      cap = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge SCK);
         if (i == 0) begin tx_data_a = nd; tx_last_a = nl; tx_valid_a = nv; end
         MISO_a = miso_w[7-i];
         cap = {cap[6:0], MOSI_a};
      end
   endtask
   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(negedge SCK);
      total++;
      if ({SSB_a, MOSI_a, rx_valid_a, busy_a} !== 6'b111000) begin
         bad++; $display("FAIL reset_ctl_a: got %b, required 111000", {SSB_a, MOSI_a, rx_valid_a, busy_a});
      end
      total++;
      if (rx_data_a !== 8'h00) begin bad++; $display("FAIL reset_rx_a: got %h, required 00", rx_data_a); end
      total++;
      if ({SSB_b, busy_b} !== 5'b11110) begin bad++; $display("FAIL reset_b: got %b, required 11110", {SSB_b, busy_b}); end
      reset = 1'b0;
      @(negedge SCK);
   endtask
   task automatic test_single;
      logic [7:0] cap;
      int r0;
      r0 = rx_cnt_a;
      tx_data_a = 8'hA5; tx_last_a = 1; tx_valid_a = 1; ss_sel_a = 0;
      total++;
      if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL single_ready_idle: got %b, required 1", tx_ready_a); end
      shift_word(8'h3C, 8'h00, 0, 0, cap);
      total++;
      if (cap !== 8'hA5) begin bad++; $display("FAIL single_mosi: got %h, required a5", cap); end
      @(negedge SCK);
      total++;
      if ({SSB_a, tx_ready_a, busy_a} !== 5'b11101) begin
         bad++; $display("FAIL single_gap: got %b, required 11101", {SSB_a, tx_ready_a, busy_a});
      end
      @(negedge SCK);
      total++;
      if ({tx_ready_a, busy_a} !== 2'b10) begin bad++; $display("FAIL single_idle: got %b, required 10", {tx_ready_a, busy_a}); end
      total++;
      if (last_run_a != 8 || pat_a !== 3'b110) begin
         bad++; $display("FAIL single_ssb: run %0d pattern %b, required 8 110", last_run_a, pat_a);
      end
      total++;
      if (rx_cnt_a - r0 != 1) begin bad++; $display("FAIL single_rx_count: got %0d, required 1", rx_cnt_a - r0); end
   endtask
   task automatic test_burst;
      logic [7:0] c1, c2;
      int r0;
      r0 = rx_cnt_a;
      tx_data_a = 8'h01; tx_last_a = 0; tx_valid_a = 1; ss_sel_a = 0;
      shift_word(8'h96, 8'h22, 1, 1, c1);
      shift_word(8'h69, 8'h00, 0, 0, c2);
      repeat (2) @(negedge SCK);
      total++;
      if ({c1, c2} !== 16'h0122) begin bad++; $display("FAIL burst_mosi: got %h, required 0122", {c1, c2}); end
      total++;
      if (last_run_a != 16) begin bad++; $display("FAIL burst_ssb_run: got %0d, required 16", last_run_a); end
      total++;
      if (rx_cnt_a - r0 != 2 || rx_cyc_a - prev_rx_cyc_a != 8) begin
         bad++; $display("FAIL burst_rx_spacing: count %0d spacing %0d, required 2 8", rx_cnt_a - r0, rx_cyc_a - prev_rx_cyc_a);
      end
   endtask
   task automatic test_hold;
      logic [7:0] c1, c2;
      tx_data_a = 8'h81; tx_last_a = 0; tx_valid_a = 1; ss_sel_a = 0;
      shift_word(8'hC3, 8'h7E, 1, 0, c1);
      for (int i = 0; i < 5; i++) begin
         @(negedge SCK);
         total++;
         if ({MOSI_a, SSB_a, tx_ready_a} !== 5'b01101) begin
            bad++; $display("FAIL hold_cycle%0d: got %b, required 01101", i, {MOSI_a, SSB_a, tx_ready_a});
         end
         if (i == 4) tx_valid_a = 1;
      end
      shift_word(8'h18, 8'h00, 0, 0, c2);
      repeat (2) @(negedge SCK);
      total++;
      if ({c1, c2} !== 16'h817E) begin bad++; $display("FAIL hold_mosi: got %h, required 817e", {c1, c2}); end
      total++;
      if (last_run_a != 21) begin bad++; $display("FAIL hold_ssb_run: got %0d, required 21", last_run_a); end
   endtask
   task automatic test_max_words;
      logic [7:0] tw [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      logic [7:0] mw [5] = '{8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5};
      logic [7:0] cap [5];
      tx_data_a = tw[0]; tx_last_a = 0; tx_valid_a = 1; ss_sel_a = 0;
      for (int w = 0; w < 4; w++) begin
         shift_word(mw[w], tw[w+1], 0, 1, cap[w]);
         if (w == 0) ss_sel_a = 1;
      end
      @(negedge SCK);
      total++;
      if ({SSB_a, tx_ready_a} !== 4'b1110) begin bad++; $display("FAIL maxw_gap: got %b, required 1110", {SSB_a, tx_ready_a}); end
      @(negedge SCK);
      total++;
      if (tx_ready_a !== 1'b1) begin bad++; $display("FAIL maxw_idle_ready: got %b, required 1", tx_ready_a); end
      total++;
      if (last_run_a != 32 || pat_a !== 3'b110) begin
         bad++; $display("FAIL maxw_frame1: run %0d pattern %b, required 32 110", last_run_a, pat_a);
      end
      tx_last_a = 1;
      shift_word(mw[4], 8'h00, 0, 0, cap[4]);
      repeat (2) @(negedge SCK);
      total++;
      if (last_run_a != 8 || pat_a !== 3'b101) begin
         bad++; $display("FAIL maxw_frame2: run %0d pattern %b, required 8 101", last_run_a, pat_a);
      end
      for (int w = 0; w < 5; w++) begin
         total++;
         if (cap[w] !== tw[w]) begin bad++; $display("FAIL maxw_mosi%0d: got %h, required %h", w, cap[w], tw[w]); end
      end
   endtask
   task automatic test_out_of_range;
      logic [7:0] cap;
      int r0;
      r0 = rx_cnt_a;
      tx_data_a = 8'h3C; tx_last_a = 1; tx_valid_a = 1; ss_sel_a = 3;
      shift_word(8'h4D, 8'h00, 0, 0, cap);
      total++;
      if ({SSB_a, busy_a} !== 4'b1111) begin bad++; $display("FAIL oor_ssb: got %b, required 1111", {SSB_a, busy_a}); end
      repeat (2) @(negedge SCK);
      total++;
      if (cap !== 8'h3C || rx_cnt_a - r0 != 1) begin
         bad++; $display("FAIL oor_frame: mosi %h rx count %0d, required 3c 1", cap, rx_cnt_a - r0);
      end
   endtask
   task automatic test_lsb_first;
      logic [7:0] cap, m;
      m = 8'hB2;
      exp_b.push_back(m);
      tx_data_b = 8'h01; tx_last_b = 1; tx_valid_b = 1; ss_sel_b = 2;
      total++;
      if (tx_ready_b !== 1'b1) begin bad++; $display("FAIL lsb_ready: got %b, required 1", tx_ready_b); end
      for (int i = 0; i < 8; i++) begin
         @(negedge SCK);
         if (i == 0) tx_valid_b = 0;
         cap[i] = MOSI_b;
         MISO_b = m[i];
         total++;
         if (SSB_b !== 4'b1011) begin bad++; $display("FAIL lsb_ssb%0d: got %b, required 1011", i, SSB_b); end
      end
      repeat (2) @(negedge SCK);
      total++;
      if (cap !== 8'h01) begin bad++; $display("FAIL lsb_mosi: got %h, required 01", cap); end
      total++;
      if (rx_cnt_b != 1 || busy_b !== 1'b0) begin bad++; $display("FAIL lsb_done: rx %0d busy %b, required 1 0", rx_cnt_b, busy_b); end
   endtask
   task automatic test_reset_mid;
      logic [7:0] cap;
      int r0;
      r0 = rx_cnt_a;
      tx_data_a = 8'hF0; tx_last_a = 1; tx_valid_a = 1; ss_sel_a = 0;
      @(negedge SCK);
      tx_valid_a = 0;
      MISO_a = 1;
      repeat (3) @(negedge SCK);
      #2 reset = 1'b1;
      #1;
      total++;
      if ({SSB_a, busy_a, rx_valid_a} !== 5'b11100) begin
         bad++; $display("FAIL mid_reset: got %b, required 11100", {SSB_a, busy_a, rx_valid_a});
      end
      @(negedge SCK);
      reset = 1'b0;
      repeat (10) @(negedge SCK);
      total++;
      if (rx_cnt_a != r0) begin bad++; $display("FAIL mid_no_rx: got %0d pulses, required 0", rx_cnt_a - r0); end
      tx_data_a = 8'h5A; tx_last_a = 1; tx_valid_a = 1; ss_sel_a = 0;
      shift_word(8'hA7, 8'h00, 0, 0, cap);
      repeat (2) @(negedge SCK);
      total++;
      if (cap !== 8'h5A || rx_cnt_a - r0 != 1 || last_run_a != 8) begin
         bad++; $display("FAIL mid_recover: mosi %h rx %0d run %0d, required 5a 1 8", cap, rx_cnt_a - r0, last_run_a);
      end
   endtask
   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_single();
      test_burst();
      test_hold();
      test_max_words();
      test_out_of_range();
      test_lsb_first();
      test_reset_mid();
      repeat (2) @(negedge SCK);
      total++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain: pending %0d %0d, required 0 0", exp_a.size(), exp_b.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end
endmodule
